// File: rtl/class_hbkt_sched.sv
// Lookup scheduler and shared table-port controller for the cuckoo hash tables T1/T2.
// Spaces lookup issues by ISSUE_GAP and fills the free cycles with table writes.
module class_hbkt_sched #(
    parameter int HASH_WIDTH = 13,
    parameter int RD_LAT     = 2,
    parameter int ISSUE_GAP  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sched_en,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic [HASH_WIDTH-1:0] req_h1k,
    input  logic [HASH_WIDTH-1:0] req_h2k,
    input  logic                  wr_req,
    input  logic                  wr_tbl,
    input  logic [HASH_WIDTH-1:0] wr_addr,
    input  logic [127:0]          wr_data,
    output logic                  wr_gnt,
    output logic                  ht_rd_en,
    output logic                  ht_t1_wr_en,
    output logic                  ht_t2_wr_en,
    output logic [HASH_WIDTH-1:0] ht_t1_addr,
    output logic [HASH_WIDTH-1:0] ht_t2_addr,
    output logic [127:0]          ht_wr_data,
    output logic                  cmp_ht_vld,
    output logic [HASH_WIDTH-1:0] cmp_h1k,
    output logic [HASH_WIDTH-1:0] cmp_h2k,
    output logic                  busy,
    output logic [15:0]           lkup_cnt,
    output logic [15:0]           wr_cnt
);

    localparam logic [3:0] GAP_LOAD = 4'(ISSUE_GAP - 1);

    logic [3:0]            gap_cnt;
    logic                  accept;
    logic [RD_LAT-1:0]     vld_dl;
    logic [HASH_WIDTH-1:0] h1_dl [RD_LAT];
    logic [HASH_WIDTH-1:0] h2_dl [RD_LAT];

    assign req_rdy = !rst && sched_en && (gap_cnt == 4'd0);
    assign accept  = req_vld && req_rdy;
    // Lookups win the port; a colliding write simply waits one cycle.
    assign wr_gnt  = !rst && wr_req && !accept;

    assign cmp_ht_vld = vld_dl[RD_LAT-1];
    assign cmp_h1k    = h1_dl[RD_LAT-1];
    assign cmp_h2k    = h2_dl[RD_LAT-1];
    assign busy       = (gap_cnt != 4'd0) || (|vld_dl) || ht_rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt     <= 4'd0;
            ht_rd_en    <= 1'b0;
            ht_t1_wr_en <= 1'b0;
            ht_t2_wr_en <= 1'b0;
            ht_t1_addr  <= '0;
            ht_t2_addr  <= '0;
            ht_wr_data  <= '0;
            vld_dl      <= '0;
            lkup_cnt    <= 16'd0;
            wr_cnt      <= 16'd0;
            for (int i = 0; i < RD_LAT; i++) begin
                h1_dl[i] <= '0;
                h2_dl[i] <= '0;
            end
        end else begin
            if (accept) begin
                gap_cnt <= GAP_LOAD;
            end else if (gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end

            ht_rd_en    <= accept;
            ht_t1_wr_en <= wr_gnt && !wr_tbl;
            ht_t2_wr_en <= wr_gnt && wr_tbl;

            // The untargeted table keeps its address during a write.
            if (accept) begin
                ht_t1_addr <= req_h1k;
                ht_t2_addr <= req_h2k;
            end else if (wr_gnt) begin
                if (wr_tbl) begin
                    ht_t2_addr <= wr_addr;
                end else begin
                    ht_t1_addr <= wr_addr;
                end
            end

            if (wr_gnt) begin
                ht_wr_data <= wr_data;
            end

            // In a read cycle the table addresses are exactly the issued hashes,
            // so the delay line taps them instead of keeping a separate copy.
            vld_dl[0] <= ht_rd_en;
            h1_dl[0]  <= ht_t1_addr;
            h2_dl[0]  <= ht_t2_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_dl[i] <= vld_dl[i-1];
                h1_dl[i]  <= h1_dl[i-1];
                h2_dl[i]  <= h2_dl[i-1];
            end

            if (accept) begin
                lkup_cnt <= lkup_cnt + 16'd1;
            end
            if (wr_gnt) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_class_hbkt_sched.sv
// Bench for class_hbkt_sched: an event-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_class_hbkt_sched;

    localparam int HW        = 13;
    localparam int RD_LAT    = 2;
    localparam int ISSUE_GAP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sched_en = 1'b0;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic [HW-1:0] req_h1k = '0;
    logic [HW-1:0] req_h2k = '0;
    logic          wr_req = 1'b0;
    logic          wr_tbl = 1'b0;
    logic [HW-1:0] wr_addr = '0;
    logic [127:0]  wr_data = '0;
    logic          wr_gnt;
    logic          ht_rd_en, ht_t1_wr_en, ht_t2_wr_en;
    logic [HW-1:0] ht_t1_addr, ht_t2_addr;
    logic [127:0]  ht_wr_data;
    logic          cmp_ht_vld;
    logic [HW-1:0] cmp_h1k, cmp_h2k;
    logic          busy;
    logic [15:0]   lkup_cnt, wr_cnt;

    class_hbkt_sched #(.HASH_WIDTH(HW), .RD_LAT(RD_LAT), .ISSUE_GAP(ISSUE_GAP)) dut (
        .clk(clk), .rst(rst), .sched_en(sched_en),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_h1k(req_h1k), .req_h2k(req_h2k),
        .wr_req(wr_req), .wr_tbl(wr_tbl), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .ht_rd_en(ht_rd_en), .ht_t1_wr_en(ht_t1_wr_en), .ht_t2_wr_en(ht_t2_wr_en),
        .ht_t1_addr(ht_t1_addr), .ht_t2_addr(ht_t2_addr), .ht_wr_data(ht_wr_data),
        .cmp_ht_vld(cmp_ht_vld), .cmp_h1k(cmp_h1k), .cmp_h2k(cmp_h2k),
        .busy(busy), .lkup_cnt(lkup_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, want, $time);
        end
    endtask

    // Reference model: tracks events by cycle number rather than internal state.
    typedef struct {
        int          t;
        logic [HW-1:0] h1;
        logic [HW-1:0] h2;
    } cev_t;

    cev_t          cmpq[$];
    int            cyc = 0;
    int            last_acc = 0;
    bit            have_acc = 0;
    bit            exp_rd = 0, exp_w1 = 0, exp_w2 = 0;
    logic [HW-1:0] m_t1 = '0, m_t2 = '0;
    logic [127:0]  m_wd = '0;
    int            m_lk = 0, m_wc = 0;
    bit            chk_on = 0;
    bit            m_acc, m_gnt, want_cmp;

    function automatic bit m_rdy();
        return !rst && sched_en && (!have_acc || (cyc - last_acc) >= ISSUE_GAP);
    endfunction

    function automatic bit m_busy();
        int hi;
        hi = (ISSUE_GAP - 1 > RD_LAT + 1) ? ISSUE_GAP - 1 : RD_LAT + 1;
        return have_acc && cyc >= last_acc + 1 && cyc <= last_acc + hi;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            m_acc = req_vld && m_rdy();
            m_gnt = wr_req && !rst && !m_acc;
            if (rst) begin
                have_acc = 0;
                cmpq.delete();
                exp_rd = 0; exp_w1 = 0; exp_w2 = 0;
                m_t1 = '0; m_t2 = '0; m_wd = '0;
                m_lk = 0; m_wc = 0;
            end else begin
                exp_rd = m_acc;
                exp_w1 = m_gnt && !wr_tbl;
                exp_w2 = m_gnt && wr_tbl;
                if (m_acc) begin
                    m_t1 = req_h1k;
                    m_t2 = req_h2k;
                    last_acc = cyc;
                    have_acc = 1;
                    m_lk = (m_lk + 1) % 65536;
                    cmpq.push_back('{cyc + 1 + RD_LAT, req_h1k, req_h2k});
                end
                if (m_gnt) begin
                    if (wr_tbl) m_t2 = wr_addr;
                    else        m_t1 = wr_addr;
                    m_wd = wr_data;
                    m_wc = (m_wc + 1) % 65536;
                end
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("m_req_rdy", req_rdy, m_rdy());
                chk("m_wr_gnt", wr_gnt, wr_req && !rst && !(req_vld && m_rdy()));
                chk("m_rd_en", ht_rd_en, exp_rd);
                chk("m_t1_wr_en", ht_t1_wr_en, exp_w1);
                chk("m_t2_wr_en", ht_t2_wr_en, exp_w2);
                chk("m_port_excl", ht_rd_en && (ht_t1_wr_en || ht_t2_wr_en), 1'b0);
                chk("m_t1_addr", ht_t1_addr, m_t1);
                chk("m_t2_addr", ht_t2_addr, m_t2);
                chk("m_wr_data", ht_wr_data, m_wd);
                want_cmp = (cmpq.size() > 0) && (cmpq[0].t == cyc);
                chk("m_cmp_vld", cmp_ht_vld, want_cmp);
                if (want_cmp) begin
                    chk("m_cmp_h1k", cmp_h1k, cmpq[0].h1);
                    chk("m_cmp_h2k", cmp_h2k, cmpq[0].h2);
                    void'(cmpq.pop_front());
                end
                chk("m_busy", busy, m_busy());
                chk("m_lkup_cnt", lkup_cnt, 16'(m_lk));
                chk("m_wr_cnt", wr_cnt, 16'(m_wc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    int  na;
    int  g;
    bit  gnt_prev;

    initial begin
        // Reset state, with request inputs active to prove the ready/grant gating.
        sched_en = 1'b1; req_vld = 1'b1; wr_req = 1'b1;
        step();
        chk_on = 1;
        #1;
        chk("rst_req_rdy", req_rdy, 1'b0);
        chk("rst_wr_gnt", wr_gnt, 1'b0);
        chk("rst_rd_en", ht_rd_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmp_vld", cmp_ht_vld, 1'b0);
        chk("rst_cmp_h1k", cmp_h1k, 13'h0);
        chk("rst_t1_addr", ht_t1_addr, 13'h0);
        chk("rst_wr_data", ht_wr_data, 128'h0);
        chk("rst_lkup_cnt", lkup_cnt, 16'h0);
        step();
        step();
        rst = 1'b0; req_vld = 1'b0; wr_req = 1'b0;

        // Single lookup at cycle A.
        step();
        req_vld = 1'b1; req_h1k = 13'h0A5; req_h2k = 13'h1F0;
        #1; chk("single_rdy", req_rdy, 1'b1);
        step();
        req_vld = 1'b0;
        #1;
        chk("single_rd_en", ht_rd_en, 1'b1);
        chk("single_t1_addr", ht_t1_addr, 13'h0A5);
        chk("single_t2_addr", ht_t2_addr, 13'h1F0);
        step();
        step();
        #1;
        chk("single_cmp_vld", cmp_ht_vld, 1'b1);
        chk("single_cmp_h1k", cmp_h1k, 13'h0A5);
        chk("single_cmp_h2k", cmp_h2k, 13'h1F0);
        chk("single_busy_hi", busy, 1'b1);
        chk("single_lkup_cnt", lkup_cnt, 16'd1);
        step();
        #1;
        chk("single_busy_lo", busy, 1'b0);
        chk("single_cmp_done", cmp_ht_vld, 1'b0);

        // Back-to-back requests held for 12 cycles.
        na = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            req_vld = 1'b1;
            req_h1k = 13'(i * 3 + 1);
            req_h2k = 13'h1000 | 13'(i);
            #1;
            chk("b2b_rdy", req_rdy, 1'((i % 4) == 0));
            if (req_rdy) na++;
        end
        step();
        req_vld = 1'b0;
        #1; chk("b2b_accepts", 32'(na), 32'd3);
        idle(4);

        // Collision: lookup and write to T2 in the same cycle.
        step();
        req_vld = 1'b1; req_h1k = 13'h0ABC; req_h2k = 13'h1F0;
        wr_req = 1'b1; wr_tbl = 1'b1; wr_addr = 13'h1F0;
        wr_data = 128'hCAFE_0000_0000_0000_0000_0000_0000_DEAD;
        #1;
        chk("coll_rdy", req_rdy, 1'b1);
        chk("coll_gnt0", wr_gnt, 1'b0);
        step();
        req_vld = 1'b0;
        #1;
        chk("coll_gnt1", wr_gnt, 1'b1);
        chk("coll_rd_en", ht_rd_en, 1'b1);
        chk("coll_t2_we_early", ht_t2_wr_en, 1'b0);
        step();
        wr_req = 1'b0;
        #1;
        chk("coll_t2_we", ht_t2_wr_en, 1'b1);
        chk("coll_t1_we", ht_t1_wr_en, 1'b0);
        chk("coll_rd_off", ht_rd_en, 1'b0);
        chk("coll_t2_addr", ht_t2_addr, 13'h1F0);
        chk("coll_t1_hold", ht_t1_addr, 13'h0ABC);
        chk("coll_wdata", ht_wr_data, 128'hCAFE_0000_0000_0000_0000_0000_0000_DEAD);
        idle(6);

        // Continuous lookups and writes: grants fill 3 of every 4 cycles.
        g = 0; gnt_prev = 0;
        wr_tbl = 1'b0; wr_addr = 13'h100; wr_data = 128'h1;
        for (int i = 0; i < 16; i++) begin
            step();
            req_vld = 1'b1; wr_req = 1'b1;
            req_h1k = 13'h0200 + 13'(i); req_h2k = 13'h0300 + 13'(i);
            if (gnt_prev) begin
                wr_tbl = g[0]; wr_addr = 13'h100 + 13'(g); wr_data = 128'(g + 1);
            end
            #1;
            chk("starve_gnt", wr_gnt, 1'((i % 4) != 0));
            gnt_prev = wr_gnt;
            if (wr_gnt) g++;
        end
        step();
        req_vld = 1'b0; wr_req = 1'b0;
        #1; chk("starve_grants", 32'(g), 32'd12);
        idle(6);

        // Disable right after an accept; the in-flight lookup still completes.
        step();
        sched_en = 1'b1; req_vld = 1'b1; req_h1k = 13'h1234; req_h2k = 13'h0567;
        #1; chk("drain_acc", req_rdy, 1'b1);
        for (int j = 1; j <= 8; j++) begin
            step();
            sched_en = 1'b0;
            #1;
            chk("drain_rdy", req_rdy, 1'b0);
            if (j == 3) begin
                chk("drain_cmp_vld", cmp_ht_vld, 1'b1);
                chk("drain_cmp_h1k", cmp_h1k, 13'h1234);
                chk("drain_busy_hi", busy, 1'b1);
            end
            if (j == 4) chk("drain_busy_lo", busy, 1'b0);
        end
        step();
        req_vld = 1'b0; sched_en = 1'b1;
        idle(2);
        #1;
        chk("tally_lkup", lkup_cnt, 16'd10);
        chk("tally_wr", wr_cnt, 16'd13);

        // Reset two cycles after an accept.
        step();
        req_vld = 1'b1; req_h1k = 13'h0111; req_h2k = 13'h0222;
        #1; chk("midrst_acc", req_rdy, 1'b1);
        step();
        req_vld = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_vld = 1'b1; req_h1k = 13'h0333; req_h2k = 13'h0444;
        #1;
        chk("midrst_cmp_vld", cmp_ht_vld, 1'b0);
        chk("midrst_lkup_cnt", lkup_cnt, 16'd0);
        chk("midrst_wr_cnt", wr_cnt, 16'd0);
        chk("midrst_t1_addr", ht_t1_addr, 13'h0);
        chk("midrst_rd_en", ht_rd_en, 1'b0);
        chk("midrst_req_rdy", req_rdy, 1'b1);
        step();
        req_vld = 1'b0;
        #1;
        chk("midrst_rd_again", ht_rd_en, 1'b1);
        chk("midrst_t1_again", ht_t1_addr, 13'h0333);
        chk("midrst_cmp_none", cmp_ht_vld, 1'b0);
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
